// File: rtl/async_fifo_core.sv
// async_fifo_core: single-clock FIFO built on Gray pointers with 2-flop cross-side synchronizers.
module async_fifo_core #(
  parameter int BITS = 32,
  parameter int SIZE = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            p_write_en,
  input  logic [BITS-1:0] p_write_data,
  output logic            p_write_full,
  input  logic            p_read_en,
  output logic [BITS-1:0] p_read_data,
  output logic            p_read_empty
);
  localparam int ADDR = $clog2(SIZE);
  // Full compares against the synced read pointer with its two MSBs flipped.
  localparam logic [ADDR:0] msk = (ADDR+1)'(3) << (ADDR-1);
  logic [BITS-1:0] mem [SIZE];
  logic [ADDR:0] wbin, wgray, rbin, rgray, wq1, wq2, rq1, rq2, wbin_n, rbin_n;
  logic wr, rd;
  assign p_read_empty = rgray == wq2;
  assign p_write_full = wgray == (rq2 ^ msk);
  assign wr = p_write_en && !p_write_full && !rst;
  assign rd = p_read_en && !p_read_empty && !rst;
  assign wbin_n = wbin + (ADDR+1)'(1);
  assign rbin_n = rbin + (ADDR+1)'(1);
  always_ff @(posedge clk) begin
    if (rst) begin
      wbin <= '0;
      wgray <= '0;
      rbin <= '0;
      rgray <= '0;
      wq1 <= '0;
      wq2 <= '0;
      rq1 <= '0;
      rq2 <= '0;
      p_read_data <= '0;
    end else begin
      if (wr) begin
        wbin <= wbin_n;
        wgray <= wbin_n ^ (wbin_n >> 1);
      end
      if (rd) begin
        rbin <= rbin_n;
        rgray <= rbin_n ^ (rbin_n >> 1);
        p_read_data <= mem[rbin[ADDR-1:0]];
      end
      wq1 <= wgray;
      wq2 <= wq1;
      rq1 <= rgray;
      rq2 <= rq1;
    end
  end
  always_ff @(posedge clk) if (wr) mem[wbin[ADDR-1:0]] <= p_write_data;
endmodule

// File: tb/tb_async_fifo_core.sv
// tb_async_fifo_core: directed stimulus with a queue scoreboard and occupancy-based flag model.
module tb_async_fifo_core;
  localparam int SIZE = 16;
  logic clk = 0, rst = 1, p_write_en = 0, p_read_en = 0;
  logic [31:0] p_write_data = 0, p_read_data;
  logic p_write_full, p_read_empty;
  int checks = 0, errors = 0;
  int wcnt, rcnt, wh1, wh2, rh1, rh2, full_rises = 0, empty_rises = 0;
  logic rd_acc = 0, armed = 0, rst_seen = 0, pf = 0, pe = 0, m_empty, m_full;
  logic [31:0] q[$];
  logic [31:0] last = 0, d = 0;

  async_fifo_core #(.BITS(32), .SIZE(SIZE)) dut (
    .clk(clk), .rst(rst), .p_write_en(p_write_en), .p_write_data(p_write_data),
    .p_write_full(p_write_full), .p_read_en(p_read_en), .p_read_data(p_read_data),
    .p_read_empty(p_read_empty));

  always #5 clk = ~clk;

  // Flags modelled from accept counts: each side sees the other's count two edges late.
  assign m_empty = rcnt == wh2;
  assign m_full = (wcnt - rh2) == SIZE;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", n, a, e, $time);
    end
  endtask

  always @(posedge clk) begin
    logic wa, ra;
    rst_seen <= rst;
    if (rst) begin
      wcnt <= 0; rcnt <= 0; wh1 <= 0; wh2 <= 0; rh1 <= 0; rh2 <= 0;
      rd_acc <= 0; armed <= 1;
      q.delete();
    end else begin
      wa = p_write_en && !m_full;
      ra = p_read_en && !m_empty;
      if (wa) q.push_back(p_write_data);
      wcnt <= wcnt + int'(wa);
      rcnt <= rcnt + int'(ra);
      wh1 <= wcnt; wh2 <= wh1; rh1 <= rcnt; rh2 <= rh1;
      rd_acc <= ra;
    end
  end

  always @(negedge clk) if (armed) begin
    if (rst_seen) last = 0;
    else if (rd_acc) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_underflow got read exp none at %0t", $time);
      end else last = q.pop_front();
    end
    chk("rdata", p_read_data, last);
    chk("empty", p_read_empty, m_empty);
    chk("full", p_write_full, m_full);
    if (p_write_full && !pf) full_rises++;
    if (p_read_empty && !pe) empty_rises++;
    pf = p_write_full;
    pe = p_read_empty;
  end

  task automatic step(input logic we, input logic [31:0] wd, input logic re);
    p_write_en = we; p_write_data = wd; p_read_en = re;
    @(negedge clk);
  endtask

  initial begin
    rst = 1;
    repeat (3) step(1, 32'hDEAD, 1);
    chk("rst_empty", p_read_empty, 1);
    chk("rst_full", p_write_full, 0);
    chk("rst_data", p_read_data, 0);
    rst = 0;
    for (int i = 0; i < 16; i++) step(1, i, 0);
    chk("smoke_full", p_write_full, 1);
    for (int i = 0; i < 16; i++) step(0, 0, 1);
    chk("smoke_last", p_read_data, 32'hF);
    chk("smoke_empty", p_read_empty, 1);
    for (int i = 0; i < 17; i++) begin
      step(1, 32'hA0 + i, 0);
      if (i == 15) chk("full_16", p_write_full, 1);
    end
    step(0, 0, 1); chk("full_hold1", p_write_full, 1);
    step(0, 0, 1); chk("full_hold2", p_write_full, 1);
    step(0, 0, 1); chk("full_clear", p_write_full, 0);
    for (int i = 0; i < 13; i++) step(0, 0, 1);
    chk("full_last", p_read_data, 32'hAF);
    chk("full_drain_empty", p_read_empty, 1);
    step(1, 32'h1234, 0); chk("e_delay1", p_read_empty, 1);
    step(0, 0, 0); chk("e_delay2", p_read_empty, 1);
    step(0, 0, 0); chk("e_clear", p_read_empty, 0);
    step(0, 0, 1); chk("e_data", p_read_data, 32'h1234); chk("e_empty", p_read_empty, 1);
    step(0, 0, 1); chk("e_hold", p_read_data, 32'h1234);
    d = 32'h1000;
    for (int i = 0; i < 200; i++) begin step(1, d, 1); d++; end
    for (int i = 0; i < 20; i++) step(0, 0, 1);
    chk("il_empty", p_read_empty, 1);
    chk("il_sb", q.size(), 0);
    for (int i = 0; i < 150; i++) begin step(1, d, i % 3 == 0); d++; end
    for (int i = 0; i < 300; i++) begin step(i % 3 == 0, d, 1); d++; end
    for (int i = 0; i < 20; i++) step(0, 0, 1);
    chk("rate_empty", p_read_empty, 1);
    chk("rate_sb", q.size(), 0);
    chk("full_toggles", full_rises >= 3, 1);
    chk("empty_toggles", empty_rises >= 3, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
